fpu_arbiter: RTL and testbench
==============================

Name: fpu_arbiter

Overview:
- Shares one FPU (operands a/b, 3-bit op, result, ready) between NUM_REQ requesters (integer pipeline, load/store unit, debug port).
- Selects requesters round-robin and sequences one FPU operation at a time.
- Returns the tagged result through a response channel with backpressure.
- Enforces a timeout, so a hung FPU cannot stall the core.

Parameters:
- NUM_REQ, 2: number of requesters, legal range 2..8.
- ID_W, 1: width of the requester id; must be at least clog2(NUM_REQ).
- TIMEOUT_CYCLES, 64: maximum number of WAIT cycles before the operation is aborted.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept strobe; one-hot or zero.
- req_a  in  32*NUM_REQ  operand A, IEEE-754 single; requester i uses bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, same packing as req_a.
- req_op  in  3*NUM_REQ  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 1xx illegal.
- fpu_a  out  32  operand A driven to the FPU.
- fpu_b  out  32  operand B driven to the FPU.
- fpu_op  out  3  opcode driven to the FPU.
- fpu_start  out  1  one-cycle strobe that launches an FPU operation.
- fpu_result  in  32  FPU result.
- fpu_ready  in  1  FPU done; sampled only in WAIT.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester that issued the operation.
- resp_data  out  32  result value.
- resp_err  out  1  set on illegal op or timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE; rr_ptr=0; every output is 0 (req_ready, fpu_a/b/op, fpu_start, resp_*, busy). Reset asserted mid-operation drops the operation with no response issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant g = first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that same cycle; the handshake completes in this cycle.
  - Latch a, b, op and id=g into the operand registers, which drive fpu_a/b/op. These registers stay stable until the next grant.
  - If op[2]=1: load resp_data=0 and resp_err=1, then go to RESP without touching the FPU.
  - Otherwise go to ISSUE.
- ISSUE: fpu_start=1 for exactly one cycle; clear the timer; go to WAIT.
- WAIT:
  - If fpu_ready=1: resp_data<=fpu_result, resp_err<=0, go to RESP.
  - Otherwise the timer increments. When the timer reaches TIMEOUT_CYCLES-1 with no ready: resp_data<=0, resp_err<=1, go to RESP.
  - If ready and timeout coincide, ready wins.
- RESP:
  - resp_valid=1, with resp_id/data/err held stable until resp_ready=1.
  - On the handshake: rr_ptr<=(id+1) mod NUM_REQ, go to IDLE.
- Latency: grant at cycle T; fpu_start at T+1; if the FPU asserts ready at T+1+k (k≥1), resp_valid is high from T+2+k.
- Throughput: at most one operation outstanding. The earliest next grant is the cycle after the response handshake; no grant is issued while in RESP.
- Fairness: a requester that holds valid continuously is served within NUM_REQ grants.
- A requester that drops valid before it is granted is simply skipped.
- req inputs are ignored outside IDLE.
- fpu_ready high during ISSUE or IDLE (stale from a previous operation) is ignored.

Test Plan:
- FPU model with 3-cycle ready. Requester 0 issues a=0x40000000, b=0x40400000, op=000.
  - fpu_start one cycle after the grant.
  - resp_id=0, resp_data=0x40A00000, resp_err=0.
  - resp_valid 5 cycles after the grant.
- Both requesters valid continuously. Req0 sends SUB 0x40800000,0x40000000; req1 sends MUL 0x40400000,0x40000000.
  - Grants alternate 0,1,0,1.
  - Responses are 0x40000000 with id 0 and 0x40C00000 with id 1.
- Req1 issues DIV 0x41000000,0x40000000 while resp_ready is held low for 4 cycles.
  - resp fields stay stable throughout.
  - resp_data=0x40800000.
  - No new grant occurs until the handshake.
- Req0 issues op=101.
  - fpu_start never pulses.
  - resp_err=1, resp_data=0, resp_id=0.
  - The FSM returns to IDLE.
- FPU model never asserts ready, with TIMEOUT_CYCLES=8.
  - resp_err=1 and resp_data=0, 8 WAIT cycles after fpu_start.
  - The following request completes normally.
- Assert rst=0 during WAIT.
  - All outputs drop to 0 immediately, before the next clock edge.
  - After release, the first request is granted to req0.

Source files
------------

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_arbiter
// Description : Round-robin arbiter that shares one FPU between NUM_REQ
//               requesters. It runs one operation at a time, returns a tagged
//               response with backpressure and aborts a hung FPU after a
//               bounded wait.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ID_W           = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    input  logic [3*NUM_REQ-1:0]    req_op,
    output logic [31:0]             fpu_a,
    output logic [31:0]             fpu_b,
    output logic [2:0]              fpu_op,
    output logic                    fpu_start,
    input  logic [31:0]             fpu_result,
    input  logic                    fpu_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [31:0]             resp_data,
    output logic                    resp_err,
    output logic                    busy
);

    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [ID_W-1:0]      r_id;
    logic [31:0]          r_a;
    logic [31:0]          r_b;
    logic [2:0]           r_op;
    logic [31:0]          r_data;
    logic                 r_err;
    logic [c_TMR_W-1:0]   r_timer;

    logic [ID_W:0]        w_scan;
    logic [ID_W-1:0]      w_grant_idx;
    logic                 w_grant_found;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [31:0]          w_sel_a;
    logic [31:0]          w_sel_b;
    logic [2:0]           w_sel_op;
    logic                 w_timeout;
    logic                 w_id_wrap;

    // Round-robin scan: lowest offset from rr_ptr with valid set wins
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan        = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
            if (w_scan >= (ID_W + 1)'(NUM_REQ)) begin
                w_scan = w_scan - (ID_W + 1)'(NUM_REQ);
            end
            if (req_valid[w_scan[ID_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan[ID_W-1:0];
            end
        end
    end

    assign w_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_idx;
    assign w_sel_a   = req_a[32*w_grant_idx +: 32];
    assign w_sel_b   = req_b[32*w_grant_idx +: 32];
    assign w_sel_op  = req_op[3*w_grant_idx +: 3];
    assign w_timeout = (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));
    assign w_id_wrap = (r_id == ID_W'(NUM_REQ - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; ready wins over a coinciding timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_found) begin
                    w_state_nxt = w_sel_op[2] ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (fpu_ready || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant strobe; gated by reset so no handshake can complete while held
    always_comb begin
        req_ready = '0;
        if (rst && (r_state == ST_IDLE) && w_grant_found) begin
            req_ready = w_onehot;
        end
    end

    // Operand latch, timer, result capture and round-robin pointer update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_id     <= '0;
            r_data   <= '0;
            r_err    <= 1'b0;
            r_timer  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_found) begin
                        r_a  <= w_sel_a;
                        r_b  <= w_sel_b;
                        r_op <= w_sel_op;
                        r_id <= w_grant_idx;
                        if (w_sel_op[2]) begin
                            r_data <= '0;
                            r_err  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: r_timer <= '0;
                ST_WAIT: begin
                    if (fpu_ready) begin
                        r_data <= fpu_result;
                        r_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_data <= '0;
                        r_err  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_rr_ptr <= w_id_wrap ? '0 : r_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fpu_a      = r_a;
    assign fpu_b      = r_b;
    assign fpu_op     = r_op;
    assign fpu_start  = (r_state == ST_ISSUE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_id    = r_id;
    assign resp_data  = r_data;
    assign resp_err   = r_err;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_arbiter
// Description : Self-checking bench for fpu_arbiter with a 3-cycle FPU model
//               and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [5:0]  req_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [2:0]  fpu_op;
    logic        fpu_start;
    logic [31:0] fpu_result;
    logic        fpu_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [0:0]  resp_id;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;

    fpu_arbiter #(
        .NUM_REQ       (2),
        .ID_W          (1),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .fpu_a     (fpu_a),
        .fpu_b     (fpu_b),
        .fpu_op    (fpu_op),
        .fpu_start (fpu_start),
        .fpu_result(fpu_result),
        .fpu_ready (fpu_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .busy      (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Per-requester stimulus and expected results
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic [2:0]  rop[2];
    logic [1:0]  rv;
    logic [31:0] exp_data[2];
    logic        exp_err [2];

    always_comb begin
        req_valid = rv;
        for (int i = 0; i < 2; i++) begin
            req_a[32*i +: 32] = ra[i];
            req_b[32*i +: 32] = rb[i];
            req_op[3*i +: 3]  = rop[i];
        end
    end

    // FPU model: ready pulses 3 cycles after the start strobe
    function automatic real s2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        real r;
        case (op)
            3'b000:  r = s2r(a) + s2r(b);
            3'b001:  r = s2r(a) - s2r(b);
            3'b010:  r = s2r(a) * s2r(b);
            3'b011:  r = s2r(a) / s2r(b);
            default: r = 0.0;
        endcase
        return r2s(r);
    endfunction

    logic [1:0]  f_cnt;
    logic [31:0] f_res;
    logic        hang;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_cnt <= 2'd0;
        end else if (fpu_start) begin
            f_cnt <= 2'd3;
            f_res <= fpu_model(fpu_a, fpu_b, fpu_op);
        end else if (f_cnt != 2'd0) begin
            f_cnt <= f_cnt - 2'd1;
        end
    end

    assign fpu_ready  = (f_cnt == 2'd1) && !hang;
    assign fpu_result = f_res;

    // Scoreboard and monitor
    typedef struct {
        logic [0:0]  id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   g_log[$];
    int   start_cnt      = 0;
    int   last_grant_cyc = 0;
    int   last_start_cyc = 0;
    int   last_valid_cyc = 0;
    logic prev_valid     = 1'b0;
    logic hold_pending   = 1'b0;
    logic [0:0]  h_id;
    logic [31:0] h_data;
    logic        h_err;

    always @(negedge clk) begin
        exp_t e;
        int   gi;
        if (rst) begin
            if (req_ready != 2'b00) begin
                gi = req_ready[1] ? 1 : 0;
                g_log.push_back(gi);
                last_grant_cyc = cyc;
                e.id   = 1'(gi);
                e.data = exp_data[gi];
                e.err  = exp_err[gi];
                sb.push_back(e);
            end
            if (fpu_start) begin
                start_cnt++;
                last_start_cyc = cyc;
            end
            if (resp_valid && !prev_valid) last_valid_cyc = cyc;
            if (resp_valid) chk("no_grant_in_resp", 64'(req_ready), 64'd0);
            if (hold_pending) begin
                chk("resp_held_valid", 64'(resp_valid), 64'd1);
                chk("resp_stable", {31'd0, resp_id, resp_data, resp_err},
                    {31'd0, h_id, h_data, h_err});
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", 64'(resp_id), 64'(e.id));
                    chk("resp_data", 64'(resp_data), 64'(e.data));
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                end
            end
            prev_valid   = resp_valid;
            hold_pending = resp_valid && !resp_ready;
            h_id         = resp_id;
            h_data       = resp_data;
            h_err        = resp_err;
        end else begin
            prev_valid   = 1'b0;
            hold_pending = 1'b0;
        end
    end

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] ed, input logic ee);
        logic got;
        ra[i]       = a;
        rb[i]       = b;
        rop[i]      = op;
        exp_data[i] = ed;
        exp_err[i]  = ee;
        rv[i]       = 1'b1;
        got         = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            #1;
            if (req_ready[i]) got = 1'b1;
            tick();
        end
        rv[i] = 1'b0;
        chk("grant_seen", 64'(got), 64'd1);
    endtask

    task automatic wait_resp(input int max);
        logic done;
        done = 1'b0;
        for (int n = 0; n < max && !done; n++) begin
            #1;
            if (resp_valid && resp_ready) done = 1'b1;
            tick();
        end
        chk("resp_seen", 64'(done), 64'd1);
    endtask

    task automatic wait_idle(input int max);
        for (int n = 0; n < max && busy; n++) tick();
        chk("idle_reached", 64'(busy), 64'd0);
    endtask

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int s0;
        tbl[0] = '{req: 0, a: 32'h3F800000, b: 32'h3F800000, op: 3'b000, exp_data: 32'h40000000, exp_err: 1'b0};
        tbl[1] = '{req: 1, a: 32'h40A00000, b: 32'h3F800000, op: 3'b001, exp_data: 32'h40800000, exp_err: 1'b0};
        tbl[2] = '{req: 0, a: 32'h40000000, b: 32'h40800000, op: 3'b010, exp_data: 32'h41000000, exp_err: 1'b0};
        tbl[3] = '{req: 1, a: 32'h41000000, b: 32'h40800000, op: 3'b011, exp_data: 32'h40000000, exp_err: 1'b0};
        tbl[4] = '{req: 0, a: 32'h40000000, b: 32'h40400000, op: 3'b101, exp_data: 32'h00000000, exp_err: 1'b1};
        tbl[5] = '{req: 1, a: 32'h41000000, b: 32'h40000000, op: 3'b111, exp_data: 32'h00000000, exp_err: 1'b1};

        for (int i = 0; i < 2; i++) begin
            ra[i] = 32'h3F800000; rb[i] = 32'h3F800000; rop[i] = 3'b000;
            exp_data[i] = 32'd0; exp_err[i] = 1'b0;
        end
        hang       = 1'b0;
        resp_ready = 1'b1;
        rv         = 2'b11;
        rst        = 1'b1;
        #1 rst     = 1'b0;
        #2;
        // Reset values, with requests pending
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_fpu_ab", {fpu_a, fpu_b}, 64'd0);
        chk("rst_ctrl", 64'({fpu_op, fpu_start, resp_valid, resp_id, resp_err, busy}), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        rv = 2'b00;
        tick(); tick();
        rst = 1'b1;
        tick();

        // Latency: ADD 2+3 from requester 0
        issue(0, 32'h40000000, 32'h40400000, 3'b000, 32'h40A00000, 1'b0);
        wait_resp(30);
        chk("lat_start", 64'(last_start_cyc - last_grant_cyc), 64'd1);
        chk("lat_resp", 64'(last_valid_cyc - last_grant_cyc), 64'd5);

        // Backpressure: DIV 8/2 from requester 1, consumer stalls 4 cycles
        resp_ready = 1'b0;
        issue(1, 32'h41000000, 32'h40000000, 3'b011, 32'h40800000, 1'b0);
        for (int n = 0; n < 30 && !resp_valid; n++) tick();
        chk("bp_valid", 64'(resp_valid), 64'd1);
        ra[0] = 32'h3F800000; rb[0] = 32'h3F800000; rop[0] = 3'b000;
        exp_data[0] = 32'h40000000; exp_err[0] = 1'b0;
        rv[0] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("bp_no_grant", 64'(req_ready), 64'd0);
            chk("bp_data", 64'(resp_data), 64'h40800000);
            tick();
        end
        resp_ready = 1'b1;
        rv[0]      = 1'b0;
        tick();
        chk("bp_idle", 64'(busy), 64'd0);

        // Alternation with both requesters continuously valid
        g_log.delete();
        ra[0] = 32'h40800000; rb[0] = 32'h40000000; rop[0] = 3'b001;
        exp_data[0] = 32'h40000000; exp_err[0] = 1'b0;
        ra[1] = 32'h40400000; rb[1] = 32'h40000000; rop[1] = 3'b010;
        exp_data[1] = 32'h40C00000; exp_err[1] = 1'b0;
        rv = 2'b11;
        for (int n = 0; n < 200 && g_log.size() < 4; n++) tick();
        rv = 2'b00;
        wait_idle(50);
        chk("alt_grants", 64'(g_log.size()), 64'd4);
        if (g_log.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("alt_order", 64'(g_log[k]), 64'(k % 2));
        end

        // Table of single operations
        for (int t = 0; t < 6; t++) begin
            s0 = start_cnt;
            issue(tbl[t].req, tbl[t].a, tbl[t].b, tbl[t].op, tbl[t].exp_data, tbl[t].exp_err);
            wait_resp(40);
            chk("tbl_grant", 64'(g_log[$]), 64'(tbl[t].req));
            chk("tbl_starts", 64'(start_cnt - s0), tbl[t].op[2] ? 64'd0 : 64'd1);
        end
        wait_idle(10);

        // Timeout with a hung FPU, then a normal operation
        hang = 1'b1;
        issue(0, 32'h3F800000, 32'h3F800000, 3'b000, 32'h00000000, 1'b1);
        wait_resp(40);
        chk("to_latency", 64'(last_valid_cyc - last_start_cyc), 64'd9);
        hang = 1'b0;
        issue(0, 32'h40400000, 32'h40000000, 3'b010, 32'h40C00000, 1'b0);
        wait_resp(30);

        // Reset during WAIT drops the operation; pointer returns to 0
        issue(1, 32'h3F800000, 32'h3F800000, 3'b000, 32'h40000000, 1'b0);
        tick();
        ra[0] = 32'h40000000; rb[0] = 32'h40400000; rop[0] = 3'b000;
        exp_data[0] = 32'h40A00000; exp_err[0] = 1'b0;
        rv  = 2'b11;
        rst = 1'b0;
        sb.delete();
        #1;
        chk("mr_req_ready", 64'(req_ready), 64'd0);
        chk("mr_fpu_ab", {fpu_a, fpu_b}, 64'd0);
        chk("mr_ctrl", 64'({fpu_op, fpu_start, resp_valid, resp_id, resp_err, busy}), 64'd0);
        chk("mr_resp_data", 64'(resp_data), 64'd0);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'd1);
        tick();
        rv = 2'b00;
        wait_resp(30);
        wait_idle(10);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
